// File: rtl/test_harness_monitor.sv
// test_harness_monitor: consumer side of the per-test fail/finish handshake.
// Holds the tests in reset for RESET_CYCLES edges, then collects sticky
// fail/finish flags while a saturating cycle counter runs against the
// watchdog. A single registered verdict is produced and frozen until reset.
module test_harness_monitor #(
  parameter int unsigned NUM_TESTS    = 1,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 test_reset,
  input  logic [NUM_TESTS-1:0] test_fail,
  input  logic [NUM_TESTS-1:0] test_finish,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] finish_mask,
  output logic [31:0]          cycles
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0]          RST_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [31:0]          TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [31:0]          CYC_MAX  = 32'hFFFF_FFFF;
  localparam logic [NUM_TESTS-1:0] ALL_FIN  = {NUM_TESTS{1'b1}};

  state_e               state_q, state_d;
  logic [31:0]          rst_cnt_q, rst_cnt_d;
  logic                 test_reset_q, test_reset_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_TESTS-1:0] fail_mask_q, fail_mask_d;
  logic [NUM_TESTS-1:0] finish_mask_q, finish_mask_d;
  logic [31:0]          cycles_q, cycles_d;

  // Masks as they will be after this edge; completion looks at these so the
  // verdict lands on the same edge as the last finish.
  logic [NUM_TESTS-1:0] fin_next;
  logic [NUM_TESTS-1:0] fail_next;
  logic                 all_fin;
  logic                 wd_expired;
  logic                 rst_last;

  assign fin_next   = finish_mask_q | test_finish;
  assign fail_next  = fail_mask_q | test_fail;
  assign all_fin    = (fin_next == ALL_FIN);
  assign wd_expired = (cycles_q == TO_LAST);
  assign rst_last   = (rst_cnt_q == RST_LAST);

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_RST;
      rst_cnt_q     <= 32'd0;
      test_reset_q  <= 1'b1;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_mask_q   <= '0;
      finish_mask_q <= '0;
      cycles_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      test_reset_q  <= test_reset_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      fail_mask_q   <= fail_mask_d;
      finish_mask_q <= finish_mask_d;
      cycles_q      <= cycles_d;
    end
  end

  // Next-state logic: RST -> RUN -> DONE, leaving DONE only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: begin
        if (rst_last) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_RST;
        end
      end
      ST_RUN: begin
        if (all_fin || wd_expired) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RST;
    endcase
  end

  // Output/datapath next values; finish takes priority over the watchdog.
  always_comb begin
    rst_cnt_d     = rst_cnt_q;
    test_reset_d  = test_reset_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    fail_mask_d   = fail_mask_q;
    finish_mask_d = finish_mask_q;
    cycles_d      = cycles_q;
    case (state_q)
      ST_RST: begin
        rst_cnt_d = rst_cnt_q + 32'd1;
        if (rst_last) begin
          test_reset_d = 1'b0;
        end else begin
          test_reset_d = 1'b1;
        end
      end
      ST_RUN: begin
        test_reset_d  = 1'b0;
        fail_mask_d   = fail_next;
        finish_mask_d = fin_next;
        if (cycles_q != CYC_MAX) begin
          cycles_d = cycles_q + 32'd1;
        end else begin
          cycles_d = cycles_q;
        end
        if (all_fin) begin
          done_d    = 1'b1;
          timeout_d = 1'b0;
          pass_d    = ~|fail_next;
        end else if (wd_expired) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          done_d    = done_q;
          timeout_d = timeout_q;
          pass_d    = pass_q;
        end
      end
      ST_DONE: begin
        test_reset_d = 1'b0;
      end
      default: begin
        test_reset_d = 1'b1;
      end
    endcase
  end

  assign test_reset  = test_reset_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_mask   = fail_mask_q;
  assign finish_mask = finish_mask_q;
  assign cycles      = cycles_q;

endmodule

// File: tb/tb_test_harness_monitor.sv
// Directed bench for test_harness_monitor with three configurations:
// a: NUM_TESTS=1 default timeout, b: NUM_TESTS=4, c: NUM_TESTS=2 TIMEOUT=10.
module tb_test_harness_monitor;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance a
  logic        rst_a, tr_a, done_a, pass_a, to_a;
  logic [0:0]  fail_a, fin_a, fm_a, nm_a;
  logic [31:0] cyc_a;
  // Instance b
  logic        rst_b, tr_b, done_b, pass_b, to_b;
  logic [3:0]  fail_b, fin_b, fm_b, nm_b;
  logic [31:0] cyc_b;
  // Instance c
  logic        rst_c, tr_c, done_c, pass_c, to_c;
  logic [1:0]  fail_c, fin_c, fm_c, nm_c;
  logic [31:0] cyc_c;

  test_harness_monitor #(.NUM_TESTS(1), .RESET_CYCLES(4), .TIMEOUT(1000)) dut_a (
    .clock(clock), .reset(rst_a), .test_reset(tr_a), .test_fail(fail_a),
    .test_finish(fin_a), .done(done_a), .pass(pass_a), .timeout(to_a),
    .fail_mask(fm_a), .finish_mask(nm_a), .cycles(cyc_a));

  test_harness_monitor #(.NUM_TESTS(4), .RESET_CYCLES(4), .TIMEOUT(1000)) dut_b (
    .clock(clock), .reset(rst_b), .test_reset(tr_b), .test_fail(fail_b),
    .test_finish(fin_b), .done(done_b), .pass(pass_b), .timeout(to_b),
    .fail_mask(fm_b), .finish_mask(nm_b), .cycles(cyc_b));

  test_harness_monitor #(.NUM_TESTS(2), .RESET_CYCLES(4), .TIMEOUT(10)) dut_c (
    .clock(clock), .reset(rst_c), .test_reset(tr_c), .test_fail(fail_c),
    .test_finish(fin_c), .done(done_c), .pass(pass_c), .timeout(to_c),
    .fail_mask(fm_c), .finish_mask(nm_c), .cycles(cyc_c));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Count edges seen with test_reset high, bounded.
  task automatic count_tr_a(output int n);
    n = 0;
    while (tr_a === 1'b1 && n < 50) begin n++; tick(); end
  endtask
  task automatic count_tr_b(output int n);
    n = 0;
    while (tr_b === 1'b1 && n < 50) begin n++; tick(); end
  endtask
  task automatic count_tr_c(output int n);
    n = 0;
    while (tr_c === 1'b1 && n < 50) begin n++; tick(); end
  endtask

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    fail_a = '0; fin_a = '0; fail_b = '0; fin_b = '0; fail_c = '0; fin_c = '0;
    #1;

    // T1: reset state, then RESET_CYCLES edges of test_reset
    ticks(2);
    check_val("a_rst_tr",    {31'd0, tr_a},   32'd1);
    check_val("a_rst_done",  {31'd0, done_a}, 32'd0);
    check_val("a_rst_pass",  {31'd0, pass_a}, 32'd0);
    check_val("a_rst_to",    {31'd0, to_a},   32'd0);
    check_val("a_rst_cyc",   cyc_a,           32'd0);
    check_val("a_rst_fm",    {31'd0, fm_a},   32'd0);
    check_val("a_rst_nm",    {31'd0, nm_a},   32'd0);
    rst_a = 1'b0;
    count_tr_a(n);
    check_val("t1_tr_edges", n, 32'd4);
    check_val("t1_tr_low",   {31'd0, tr_a},   32'd0);
    check_val("t1_done",     {31'd0, done_a}, 32'd0);

    // T2: finish on RUN edge 1 -> verdict on the same edge
    fin_a = 1'b1;
    tick();
    check_val("t2_done", {31'd0, done_a}, 32'd1);
    check_val("t2_pass", {31'd0, pass_a}, 32'd1);
    check_val("t2_to",   {31'd0, to_a},   32'd0);
    check_val("t2_cyc",  cyc_a,           32'd1);
    check_val("t2_nm",   {31'd0, nm_a},   32'd1);
    // DONE ignores inputs
    fin_a = 1'b0; fail_a = 1'b1;
    ticks(5);
    check_val("t2_frz_fm",   {31'd0, fm_a},   32'd0);
    check_val("t2_frz_cyc",  cyc_a,           32'd1);
    check_val("t2_frz_pass", {31'd0, pass_a}, 32'd1);
    check_val("t2_frz_tr",   {31'd0, tr_a},   32'd0);

    // T6: reset mid-RUN with a latched fail, then a clean run
    fail_a = 1'b0;
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    count_tr_a(n);
    check_val("t6_tr_edges1", n, 32'd4);
    tick();                       // RUN edge 1
    fail_a = 1'b1; tick();        // RUN edge 2
    fail_a = 1'b0; tick();        // RUN edge 3
    check_val("t6_fm_pre",  {31'd0, fm_a}, 32'd1);
    check_val("t6_cyc_pre", cyc_a,         32'd3);
    rst_a = 1'b1; tick();         // reset on RUN edge 4
    check_val("t6_fm_rst",  {31'd0, fm_a},   32'd0);
    check_val("t6_cyc_rst", cyc_a,           32'd0);
    check_val("t6_tr_rst",  {31'd0, tr_a},   32'd1);
    check_val("t6_dn_rst",  {31'd0, done_a}, 32'd0);
    rst_a = 1'b0;
    count_tr_a(n);
    check_val("t6_tr_edges2", n, 32'd4);
    ticks(2);
    fin_a = 1'b1; tick();         // RUN edge 3
    fin_a = 1'b0;
    check_val("t6_done", {31'd0, done_a}, 32'd1);
    check_val("t6_pass", {31'd0, pass_a}, 32'd1);
    check_val("t6_cyc",  cyc_a,           32'd3);
    check_val("t6_fm",   {31'd0, fm_a},   32'd0);

    // T3: four tests, finishes on RUN edges 3,5,5,9; test 2 fails on edge 5
    rst_b = 1'b0;
    count_tr_b(n);
    check_val("t3_tr_edges", n, 32'd4);
    for (int e = 1; e <= 9; e++) begin
      fin_b  = (e == 3) ? 4'b0001 : (e == 5) ? 4'b0110 : (e == 9) ? 4'b1000 : 4'b0000;
      fail_b = (e == 5) ? 4'b0100 : 4'b0000;
      tick();
      if (e == 8) check_val("t3_done_e8", {31'd0, done_b}, 32'd0);
    end
    fin_b = 4'b0000; fail_b = 4'b0000;
    check_val("t3_done", {31'd0, done_b}, 32'd1);
    check_val("t3_pass", {31'd0, pass_b}, 32'd0);
    check_val("t3_to",   {31'd0, to_b},   32'd0);
    check_val("t3_fm",   {28'd0, fm_b},   32'h4);
    check_val("t3_nm",   {28'd0, nm_b},   32'hF);
    check_val("t3_cyc",  cyc_b,           32'd9);

    // T4: TIMEOUT=10, only test 0 finishes
    rst_c = 1'b0;
    count_tr_c(n);
    check_val("t4_tr_edges", n, 32'd4);
    for (int e = 1; e <= 10; e++) begin
      fin_c = (e == 2) ? 2'b01 : 2'b00;
      tick();
      if (e == 9) check_val("t4_done_e9", {31'd0, done_c}, 32'd0);
    end
    check_val("t4_done", {31'd0, done_c}, 32'd1);
    check_val("t4_to",   {31'd0, to_c},   32'd1);
    check_val("t4_pass", {31'd0, pass_c}, 32'd0);
    check_val("t4_nm",   {30'd0, nm_c},   32'h1);
    check_val("t4_cyc",  cyc_c,           32'd10);
    fin_c = 2'b11; fail_c = 2'b11;
    ticks(20);
    check_val("t4_frz_to",   {31'd0, to_c},   32'd1);
    check_val("t4_frz_pass", {31'd0, pass_c}, 32'd0);
    check_val("t4_frz_nm",   {30'd0, nm_c},   32'h1);
    check_val("t4_frz_fm",   {30'd0, fm_c},   32'h0);
    check_val("t4_frz_cyc",  cyc_c,           32'd10);

    // T5: last finish on RUN edge 10 beats the watchdog
    fin_c = 2'b00; fail_c = 2'b00;
    rst_c = 1'b1; tick(); rst_c = 1'b0;
    count_tr_c(n);
    check_val("t5_tr_edges", n, 32'd4);
    for (int e = 1; e <= 10; e++) begin
      fin_c = (e == 1) ? 2'b01 : (e == 10) ? 2'b10 : 2'b00;
      tick();
      if (e == 9) check_val("t5_done_e9", {31'd0, done_c}, 32'd0);
    end
    fin_c = 2'b00;
    check_val("t5_done", {31'd0, done_c}, 32'd1);
    check_val("t5_to",   {31'd0, to_c},   32'd0);
    check_val("t5_pass", {31'd0, pass_c}, 32'd1);
    check_val("t5_cyc",  cyc_c,           32'd10);
    check_val("t5_nm",   {30'd0, nm_c},   32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
